led_sequencer: RTL

//   Button-driven pattern controller for the board's 8 user LEDs (LED0..LED7); sits between top-level pins and LED pads.

---
 rtl/led_sequencer_pkg.sv | 16 +
 rtl/led_sequencer_btn_debounce.sv | 41 ++++
 rtl/led_sequencer.sv | 108 ++++++++++
 3 files changed

// File: rtl/led_sequencer_pkg.sv
// led_sequencer_pkg: mode encodings and initial patterns shared by the LED sequencer.
package led_sequencer_pkg;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_BLINK = 2'd1;
    localparam logic [1:0] MODE_SCAN  = 2'd2;
    localparam logic [1:0] MODE_COUNT = 2'd3;

    localparam logic [7:0] BLINK_INIT = 8'hFF;
    localparam logic [7:0] SCAN_INIT  = 8'h01;

    function automatic logic [7:0] init_pattern(input logic [1:0] m);
        return m == MODE_BLINK ? BLINK_INIT : m == MODE_SCAN ? SCAN_INIT : 8'h00;
    endfunction

endpackage

// File: rtl/led_sequencer_btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stability debouncer and one-cycle press pulse on accepted 0->1.
module btn_debounce #(
    parameter int DEB_CYCLES = 120_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic s1_q, s2_q, level_q, press_q;
    logic [CW-1:0] cnt_q;
    logic flip;

    // the level flips on the DEB_CYCLES-th consecutive sample that differs from it
    assign flip = (s2_q != level_q) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            s1_q    <= btn_raw;
            s2_q    <= s1_q;
            cnt_q   <= (s2_q == level_q || flip) ? '0 : cnt_q + 1'b1;
            level_q <= level_q ^ flip;
            press_q <= flip & ~level_q;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: button-driven 4-mode pattern controller for 8 LEDs.
// Optional PWM dimming of the LED outputs is enabled by defining LED_DIM_EN.
module led_sequencer
    import led_sequencer_pkg::*;
#(
    parameter int CLK_HZ     = 12_000_000,
    parameter int STEP_HZ    = 4,
    parameter int DEB_CYCLES = 120_000,
    parameter int DIM_LEVEL  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_pause,
    output logic [7:0] leds,
    output logic [1:0] mode,
    output logic       paused,
    output logic       step
);

    localparam int DIV = CLK_HZ / STEP_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);

    logic mode_press, pause_press, mode_lvl_unused, pause_lvl_unused;
    logic [PW-1:0] pre_q, pre_d;
    logic [1:0] mode_q, mode_d;
    logic [7:0] pat_q, pat_d;
    logic dir_q, dir_d, paused_q, paused_d, step_q, step_d, tick;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk(clk), .rst(rst), .btn_raw(btn_mode), .level(mode_lvl_unused), .press(mode_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pause (
        .clk(clk), .rst(rst), .btn_raw(btn_pause), .level(pause_lvl_unused), .press(pause_press)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q    <= '0;
            mode_q   <= MODE_OFF;
            pat_q    <= 8'h00;
            dir_q    <= 1'b1;
            paused_q <= 1'b0;
            step_q   <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            mode_q   <= mode_d;
            pat_q    <= pat_d;
            dir_q    <= dir_d;
            paused_q <= paused_d;
            step_q   <= step_d;
        end
    end

    assign tick = !paused_q && pre_q == DIV_LAST;

    // a mode press overrides a coincident tick: the new mode's pattern loads without a step
    always_comb begin
        mode_d   = mode_q + {1'b0, mode_press};
        paused_d = paused_q ^ pause_press;
        pre_d    = mode_press ? '0 : paused_q ? pre_q : tick ? '0 : pre_q + 1'b1;
        step_d   = tick && !mode_press;
        pat_d    = pat_q;
        dir_d    = dir_q;
        if (mode_press) begin
            pat_d = init_pattern(mode_d);
            dir_d = 1'b1;
        end else if (tick) begin
            case (mode_q)
                MODE_BLINK: pat_d = ~pat_q;
                MODE_SCAN: begin
                    dir_d = dir_q ? pat_q != 8'h80 : pat_q == 8'h01;
                    pat_d = dir_d ? pat_q << 1 : pat_q >> 1;
                end
                MODE_COUNT: pat_d = pat_q + 8'd1;
                default:    pat_d = 8'h00;
            endcase
        end
    end

`ifdef LED_DIM_EN
    localparam logic [4:0] DIM_L = 5'(DIM_LEVEL);
    logic [3:0] pwm_q;

    always_ff @(posedge clk) begin
        pwm_q <= rst ? 4'd0 : pwm_q + 4'd1;
    end

    always_comb begin
        leds   = pat_q & {8{{1'b0, pwm_q} < DIM_L}};
        mode   = mode_q;
        paused = paused_q;
        step   = step_q;
    end
`else
    localparam int dim_level_unused = DIM_LEVEL;

    always_comb begin
        leds   = pat_q;
        mode   = mode_q;
        paused = paused_q;
        step   = step_q;
    end
`endif

endmodule
